// File: rtl/wb_cache_pkg.sv
// Shared types, constants and address-field helpers for the write-back cache controller.
package wb_cache_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned LINES  = 32'(1) << IDX_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    WB     = 3'd2,
    FILL   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic MEM_RD   = 1'b0;
  localparam logic MEM_WR   = 1'b1;
  localparam logic WSRC_CPU = 1'b0;
  localparam logic WSRC_MEM = 1'b1;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[OFF_W +: IDX_W];
  endfunction

  function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0];
  endfunction

endpackage

// File: rtl/wb_tag_array.sv
// Per-line valid/dirty/tag storage: async clear, combinational read, fill and dirty set/clear.
module wb_tag_array
  import wb_cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_fill,
  input  logic             i_set_dirty,
  input  logic             i_clr_dirty,
  output logic             o_valid,
  output logic             o_dirty,
  output logic [TAG_W-1:0] o_tag
);

  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag [LINES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_dirty <= '0;
      for (int i = 0; i < LINES; i++) r_tag[i] <= '0;
    end else begin
      if (i_fill) begin
        r_valid[i_idx] <= 1'b1;
        r_tag[i_idx]   <= i_tag;
      end
      // A completed fill always leaves the line clean
      if (i_set_dirty)                r_dirty[i_idx] <= 1'b1;
      else if (i_clr_dirty || i_fill) r_dirty[i_idx] <= 1'b0;
    end
  end

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];

endmodule

// File: rtl/wb_cache_ctrl.sv
// Write-back direct-mapped cache controller: lookup, dirty-victim writeback and line fill
// for the one load/store granted by the arbiter.
module wb_cache_ctrl
  import wb_cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              rd_wrt_ca,
  input  logic [ADDR_W-1:0] addr,
  output logic              idle,
  output logic              done,
  output logic              ca_rd,
  output logic              ca_we,
  output logic              ca_wsrc,
  output logic [IDX_W-1:0]  ca_idx,
  output logic [OFF_W-1:0]  ca_word,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack
);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd;
  logic [OFF_W-1:0]  r_cnt;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [OFF_W-1:0]  w_off;
  logic              w_valid, w_dirty, w_hit;
  logic [TAG_W-1:0]  w_tag_arr;
  logic              w_fill, w_set_dirty, w_clr_dirty, w_cnt_inc;

  assign w_tag = addr_tag(r_addr);
  assign w_idx = addr_idx(r_addr);
  assign w_off = addr_off(r_addr);
  assign w_hit = w_valid && (w_tag_arr == w_tag);

  wb_tag_array u_tags (
    .clk         (clk),
    .rst         (rst),
    .i_idx       (w_idx),
    .i_tag       (w_tag),
    .i_fill      (w_fill),
    .i_set_dirty (w_set_dirty),
    .i_clr_dirty (w_clr_dirty),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_tag_arr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Request capture happens only in IDLE; the beat counter wraps after the last beat of a phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_rd   <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (r_state == IDLE && enable) begin
        r_addr <= addr;
        r_rd   <= rd_wrt_ca;
      end
      if (w_cnt_inc) r_cnt <= r_cnt + OFF_W'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    idle        = 1'b0;
    done        = 1'b0;
    ca_rd       = 1'b0;
    ca_we       = 1'b0;
    ca_wsrc     = WSRC_CPU;
    ca_idx      = '0;
    ca_word     = '0;
    mem_req     = 1'b0;
    mem_we      = MEM_RD;
    mem_addr    = '0;
    w_fill      = 1'b0;
    w_set_dirty = 1'b0;
    w_clr_dirty = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        idle = 1'b1;
        if (enable) w_next = LOOKUP;
      end
      LOOKUP: begin
        if (w_hit) begin
          ca_idx  = w_idx;
          ca_word = w_off;
          if (r_rd) begin
            ca_rd = 1'b1;
          end else begin
            ca_we       = 1'b1;
            w_set_dirty = 1'b1;
          end
          w_next = DONE;
        end else if (w_valid && w_dirty) begin
          w_next = WB;
        end else begin
          w_next = FILL;
        end
      end
      WB: begin
        mem_req  = 1'b1;
        mem_we   = MEM_WR;
        mem_addr = {w_tag_arr, w_idx, r_cnt};
        ca_rd    = 1'b1;
        ca_idx   = w_idx;
        ca_word  = r_cnt;
        if (mem_ack) begin
          w_cnt_inc = 1'b1;
          if (r_cnt == '1) begin
            w_clr_dirty = 1'b1;
            w_next      = FILL;
          end
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, r_cnt};
        ca_idx   = w_idx;
        ca_word  = r_cnt;
        // Returning beat is written straight into the data RAM on its ack
        if (mem_ack) begin
          ca_we     = 1'b1;
          ca_wsrc   = WSRC_MEM;
          w_cnt_inc = 1'b1;
          if (r_cnt == '1) begin
            w_fill = 1'b1;
            w_next = LOOKUP;
          end
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Randomized bench for wb_cache_ctrl against a line-level cache model with planned memory stalls.
module tb_wb_cache_ctrl;
  import wb_cache_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic              rd_wrt_ca = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic              mem_ack = 1'b0;
  logic              idle, done, ca_rd, ca_we, ca_wsrc, mem_req, mem_we;
  logic [IDX_W-1:0]  ca_idx;
  logic [OFF_W-1:0]  ca_word;
  logic [ADDR_W-1:0] mem_addr;

  int n_chk = 0;
  int n_bad = 0;

  bit m_valid [16];
  bit m_dirty [16];
  int m_tag   [16];

  always #5 clk = ~clk;

  wb_cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rd_wrt_ca (rd_wrt_ca),
    .addr      (addr),
    .idle      (idle),
    .done      (done),
    .ca_rd     (ca_rd),
    .ca_we     (ca_we),
    .ca_wsrc   (ca_wsrc),
    .ca_idx    (ca_idx),
    .ca_word   (ca_word),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {idle, done, ca_rd, ca_we, ca_wsrc, ca_idx, ca_word, mem_req, mem_we, mem_addr}
  function automatic logic [31:0] obs();
    return {3'b0, idle, done, ca_rd, ca_we, ca_wsrc, ca_idx, ca_word, mem_req, mem_we, mem_addr};
  endfunction

  function automatic logic [31:0] beat_word(bit wb, int tg, int idx, int w, bit acked);
    logic [15:0] a;
    a = 16'((tg << 6) | (idx << 2) | w);
    return {3'b0, 1'b0, 1'b0, wb, (!wb && acked), (!wb && acked), 4'(idx), 2'(w), 1'b1, wb, a};
  endfunction

  task automatic model_clear();
    for (int j = 0; j < 16; j++) begin
      m_valid[j] = 1'b0;
      m_dirty[j] = 1'b0;
      m_tag[j]   = 0;
    end
  endtask

  // wfix < 0 draws random stalls; abort > 0 resets the DUT after that many beats
  task automatic do_op(input bit rd, input int a, input int wfix, input bit hold, input int abort);
    int t, i, o, oldt, nwb, nb, lat, k, wc, done_cyc, n_done, idle_err, extra, hev, hev_cyc;
    bit hit;
    int waits [8];
    logic [31:0] hev_val, exp_hit;
    t = a >> 6; i = (a >> 2) & 15; o = a & 3;
    oldt = m_tag[i];
    hit  = m_valid[i] && (m_tag[i] == t);
    nwb  = (!hit && m_valid[i] && m_dirty[i]) ? 4 : 0;
    nb   = hit ? 0 : nwb + 4;
    lat  = hit ? 2 : 3;
    for (int j = 0; j < nb; j++) begin
      waits[j] = (wfix >= 0) ? wfix : int'($urandom_range(0, 2));
      lat += waits[j] + 1;
    end
    k = 0; wc = 0; done_cyc = -1; n_done = 0; idle_err = 0; extra = 0; hev = 0; hev_cyc = -1;
    hev_val = '0;
    exp_hit = {3'b0, 1'b0, 1'b0, rd, !rd, 1'b0, 4'(i), 2'(o), 1'b0, 1'b0, 16'h0};

    @(negedge clk);
    enable = 1'b1; rd_wrt_ca = rd; addr = 16'(a);
    for (int cyc = 1; cyc <= lat + 1; cyc++) begin
      @(negedge clk);
      addr = 16'($urandom); rd_wrt_ca = 1'($urandom);
      if (abort > 0 && k == abort) begin
        rst = 1'b0; mem_ack = 1'b0; enable = 1'b0;
        #1;
        chk("reset_outputs", obs(), 32'h1000_0000);
        model_clear();
        #2 rst = 1'b1;
        return;
      end
      if (mem_req) begin
        if (k >= nb) begin
          extra++;
          mem_ack = 1'b0;
          #1;
        end else if (wc < waits[k]) begin
          mem_ack = 1'b0;
          #1;
          chk("stall", obs(), (k < nwb) ? beat_word(1, oldt, i, k, 0) : beat_word(0, t, i, k - nwb, 0));
          wc++;
        end else begin
          mem_ack = 1'b1;
          #1;
          chk("beat", obs(), (k < nwb) ? beat_word(1, oldt, i, k, 1) : beat_word(0, t, i, k - nwb, 1));
          k++;
          wc = 0;
        end
      end else begin
        mem_ack = 1'($urandom);
        #1;
        if (ca_rd || ca_we) begin
          hev++; hev_cyc = cyc; hev_val = obs();
        end
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc <= lat && idle) idle_err++;
      if (cyc == lat + 1) chk("idle_after", 32'(idle), 1);
      if ((!hold && cyc == lat) || cyc == lat + 1) enable = 1'b0;
    end
    mem_ack = 1'b0;
    chk("done_cycle", done_cyc, lat);
    chk("done_count", n_done, 1);
    chk("idle_during", idle_err, 0);
    chk("extra_beats", extra, 0);
    chk("beat_count", k, nb);
    chk("access_count", hev, 1);
    chk("access_cycle", hev_cyc, lat - 1);
    chk("access_value", hev_val, exp_hit);

    m_valid[i] = 1'b1;
    m_tag[i]   = t;
    m_dirty[i] = rd ? (hit ? m_dirty[i] : 1'b0) : 1'b1;
  endtask

  initial begin
    model_clear();
    #1;
    chk("reset_state", obs(), 32'h1000_0000);
    #11 rst = 1'b1;

    do_op(1, 'h0124, 0, 0, 0);
    do_op(0, 'h0126, 0, 0, 0);
    do_op(1, 'h0524, 0, 0, 0);
    do_op(0, 'h0124, 0, 0, 0);
    do_op(1, 'h0524, 5, 0, 0);
    do_op(1, 'h0124, -1, 0, 2);
    do_op(1, 'h0124, 0, 0, 0);
    do_op(1, 'h0124, 0, 1, 0);
    do_op(0, 'h0525, 1, 1, 0);

    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom),
            int'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3)),
            -1, ($urandom_range(0, 3) == 0), 0);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
